// File: rtl/tag_port_arbiter_pkg.sv
// tag_port_arbiter_pkg
// Shared size defaults and grant encoding for the tag-port arbiter and its
// update FIFO.
package tag_port_arbiter_pkg;

  localparam int ADDR_WIDTH       = 64;
  localparam int OFFSET_SIZE_DEF  = 5;
  localparam int INDEX_SIZE_DEF   = 8;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    GRANT_NONE   = 2'd0,
    GRANT_FETCH  = 2'd1,
    GRANT_UPDATE = 2'd2
  } grant_e;

endpackage

// File: rtl/tag_update_fifo.sv
// tag_update_fifo
// Two-entry FIFO holding pending tag writes from the refill path.
// Ports:
//   clock_i, reset_i       clock, synchronous active-high reset
//   push_i, push_tag,
//   push_index             write side (caller guarantees not full)
//   pop_i                  remove head (caller guarantees not empty)
//   count                  occupancy 0..2
//   head_tag, head_index   oldest entry
//   entry_valid,
//   entry_index            per-slot view used for index hazard compare
module tag_update_fifo
  import tag_port_arbiter_pkg::*;
#(
  parameter int TAG_SIZE   = ADDR_WIDTH - (OFFSET_SIZE_DEF + INDEX_SIZE_DEF),
  parameter int INDEX_SIZE = INDEX_SIZE_DEF
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic [TAG_SIZE-1:0]        push_tag,
  input  logic [INDEX_SIZE-1:0]      push_index,
  input  logic                       pop_i,
  output logic [1:0]                 count,
  output logic [TAG_SIZE-1:0]        head_tag,
  output logic [INDEX_SIZE-1:0]      head_index,
  output logic [1:0]                 entry_valid,
  output logic [1:0][INDEX_SIZE-1:0] entry_index
);

  logic [TAG_SIZE-1:0]   tag_mem   [2];
  logic [INDEX_SIZE-1:0] index_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push_i) wr_ptr <= ~wr_ptr;
      if (pop_i)  rd_ptr <= ~rd_ptr;
      case ({push_i, pop_i})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: slot contents are only observed through count.
  always_ff @(posedge clock_i) begin
    if (push_i) begin
      tag_mem[wr_ptr]   <= push_tag;
      index_mem[wr_ptr] <= push_index;
    end
  end

  assign head_tag   = tag_mem[rd_ptr];
  assign head_index = index_mem[rd_ptr];

  // With one entry only the slot under rd_ptr holds live data.
  always_comb begin
    entry_valid[0] = (count == 2'd2) || ((count == 2'd1) && (rd_ptr == 1'b0));
    entry_valid[1] = (count == 2'd2) || ((count == 2'd1) && (rd_ptr == 1'b1));
    entry_index[0] = index_mem[0];
    entry_index[1] = index_mem[1];
  end

endmodule

// File: rtl/tag_port_arbiter.sv
// tag_port_arbiter
// Arbitrates the single tag-array port between cache lookups (fetch) and
// refill tag writes (update). Updates are queued in a 2-entry FIFO; a fetch
// whose index matches a queued update is held until that update drains, and
// an update is forced through after STARVE_LIMIT consecutive fetch grants.
// Ports:
//   clock_i, reset_i                     clock, synchronous active-high reset
//   fetchValid_i/Tag/Index/Offset,
//   fetchReady_o                         lookup request, accepted this cycle
//   updValid_i/Tag/Index, updReady_o     refill tag write, FIFO not full
//   fetchEnable_o, tag_o, index_o,
//   offset_o                             registered lookup to tag-query stage
//   updateEnable_o, newTag_o, newIndex_o registered write to tag-query stage
//   updCount_o, hazardStall_o            FIFO occupancy, fetch held by hazard
module tag_port_arbiter
  import tag_port_arbiter_pkg::*;
#(
  parameter int OFFSET_SIZE  = OFFSET_SIZE_DEF,
  parameter int INDEX_SIZE   = INDEX_SIZE_DEF,
  parameter int TAG_SIZE     = ADDR_WIDTH - (OFFSET_SIZE + INDEX_SIZE),
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   fetchValid_i,
  input  logic [TAG_SIZE-1:0]    fetchTag_i,
  input  logic [INDEX_SIZE-1:0]  fetchIndex_i,
  input  logic [OFFSET_SIZE-1:0] fetchOffset_i,
  output logic                   fetchReady_o,
  input  logic                   updValid_i,
  input  logic [TAG_SIZE-1:0]    updTag_i,
  input  logic [INDEX_SIZE-1:0]  updIndex_i,
  output logic                   updReady_o,
  output logic                   fetchEnable_o,
  output logic [TAG_SIZE-1:0]    tag_o,
  output logic [INDEX_SIZE-1:0]  index_o,
  output logic [OFFSET_SIZE-1:0] offset_o,
  output logic                   updateEnable_o,
  output logic [TAG_SIZE-1:0]    newTag_o,
  output logic [INDEX_SIZE-1:0]  newIndex_o,
  output logic [1:0]             updCount_o,
  output logic                   hazardStall_o
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  grant_e                      grant;
  logic                        push;
  logic                        pop;
  logic                        hazard;
  logic                        fifo_nonempty;
  logic                        starved;
  logic [STARVE_W-1:0]         starve_cnt;
  logic [1:0]                  count;
  logic [TAG_SIZE-1:0]         head_tag;
  logic [INDEX_SIZE-1:0]       head_index;
  logic [1:0]                  entry_valid;
  logic [1:0][INDEX_SIZE-1:0]  entry_index;

  tag_update_fifo #(
    .TAG_SIZE   (TAG_SIZE),
    .INDEX_SIZE (INDEX_SIZE)
  ) u_fifo (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .push_i      (push),
    .push_tag    (updTag_i),
    .push_index  (updIndex_i),
    .pop_i       (pop),
    .count       (count),
    .head_tag    (head_tag),
    .head_index  (head_index),
    .entry_valid (entry_valid),
    .entry_index (entry_index)
  );

  // Readiness comes from the registered count, so a same-cycle pop never
  // frees room for a push.
  assign updReady_o    = !reset_i && (count != 2'd2);
  assign push          = updValid_i && updReady_o;
  assign pop           = (grant == GRANT_UPDATE);
  assign fifo_nonempty = (count != 2'd0);
  assign starved       = (starve_cnt == STARVE_W'(STARVE_LIMIT));
  assign updCount_o    = count;

  always_comb begin
    hazard = fetchValid_i &&
             ((entry_valid[0] && (entry_index[0] == fetchIndex_i)) ||
              (entry_valid[1] && (entry_index[1] == fetchIndex_i)));
  end
  assign hazardStall_o = hazard;

  always_comb begin
    grant = GRANT_NONE;
    if (reset_i) begin
      grant = GRANT_NONE;
    end else if (fifo_nonempty && (!fetchValid_i || starved || hazard)) begin
      grant = GRANT_UPDATE;
    end else if (fetchValid_i) begin
      grant = GRANT_FETCH;
    end
  end
  assign fetchReady_o = (grant == GRANT_FETCH);

  always_ff @(posedge clock_i) begin
    if (reset_i || !fifo_nonempty || (grant == GRANT_UPDATE)) begin
      starve_cnt <= '0;
    end else if ((grant == GRANT_FETCH) && !starved) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  // Registered tag-query interface; the side not granted is driven to zero.
  always_ff @(posedge clock_i) begin
    fetchEnable_o  <= 1'b0;
    tag_o          <= '0;
    index_o        <= '0;
    offset_o       <= '0;
    updateEnable_o <= 1'b0;
    newTag_o       <= '0;
    newIndex_o     <= '0;
    if (!reset_i) begin
      case (grant)
        GRANT_FETCH: begin
          fetchEnable_o <= 1'b1;
          tag_o         <= fetchTag_i;
          index_o       <= fetchIndex_i;
          offset_o      <= fetchOffset_i;
        end
        GRANT_UPDATE: begin
          updateEnable_o <= 1'b1;
          newTag_o       <= head_tag;
          newIndex_o     <= head_index;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tag_port_arbiter.sv
module tb_tag_port_arbiter;

  localparam int OS = 5;
  localparam int IS = 8;
  localparam int TS = 64 - (OS + IS);
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          fv;
  logic [TS-1:0] ftag;
  logic [IS-1:0] fidx;
  logic [OS-1:0] foff;
  logic          fetchReady_o;
  logic          uv;
  logic [TS-1:0] utag;
  logic [IS-1:0] uidx;
  logic          updReady_o;
  logic          fetchEnable_o;
  logic [TS-1:0] tag_o;
  logic [IS-1:0] index_o;
  logic [OS-1:0] offset_o;
  logic          updateEnable_o;
  logic [TS-1:0] newTag_o;
  logic [IS-1:0] newIndex_o;
  logic [1:0]    updCount_o;
  logic          hazardStall_o;

  always #5 clk = ~clk;

  tag_port_arbiter #(
    .OFFSET_SIZE  (OS),
    .INDEX_SIZE   (IS),
    .TAG_SIZE     (TS),
    .STARVE_LIMIT (SL)
  ) dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .fetchValid_i   (fv),
    .fetchTag_i     (ftag),
    .fetchIndex_i   (fidx),
    .fetchOffset_i  (foff),
    .fetchReady_o   (fetchReady_o),
    .updValid_i     (uv),
    .updTag_i       (utag),
    .updIndex_i     (uidx),
    .updReady_o     (updReady_o),
    .fetchEnable_o  (fetchEnable_o),
    .tag_o          (tag_o),
    .index_o        (index_o),
    .offset_o       (offset_o),
    .updateEnable_o (updateEnable_o),
    .newTag_o       (newTag_o),
    .newIndex_o     (newIndex_o),
    .updCount_o     (updCount_o),
    .hazardStall_o  (hazardStall_o)
  );

  // Reference model: queue of pending writes, a starvation tally, and the
  // transfer expected on the tag-query port in the next cycle.
  typedef struct {
    logic [TS-1:0] tag;
    logic [IS-1:0] idx;
  } upd_t;

  upd_t          q[$];
  int            starve;
  logic          m_fe, m_ue;
  logic [TS-1:0] m_tag, m_ntag;
  logic [IS-1:0] m_idx, m_nidx;
  logic [OS-1:0] m_off;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic clear_out();
    m_fe = 0; m_ue = 0; m_tag = '0; m_ntag = '0;
    m_idx = '0; m_nidx = '0; m_off = '0;
  endtask

  // One clock: compare every output against the model at the falling edge,
  // advance the model, then return just after the next rising edge.
  task automatic step();
    int   g;
    int   sz;
    bit   haz;
    bit   rdy;
    upd_t e;
    @(negedge clk);
    sz  = q.size();
    haz = 0;
    foreach (q[i]) if (fv && q[i].idx == fidx) haz = 1;
    rdy = !rst && sz < 2;
    if (rst)                                   g = 0;
    else if (sz > 0 && (!fv || starve == SL || haz)) g = 2;
    else if (fv)                               g = 1;
    else                                       g = 0;

    chk("upd_ready",   64'(updReady_o),    64'(rdy));
    chk("upd_count",   64'(updCount_o),    64'(sz));
    chk("hazard",      64'(hazardStall_o), 64'(haz));
    chk("fetch_ready", 64'(fetchReady_o),  64'(g == 1));
    chk("fetch_en",    64'(fetchEnable_o), 64'(m_fe));
    chk("tag",         64'(tag_o),         64'(m_tag));
    chk("index",       64'(index_o),       64'(m_idx));
    chk("offset",      64'(offset_o),      64'(m_off));
    chk("update_en",   64'(updateEnable_o),64'(m_ue));
    chk("new_tag",     64'(newTag_o),      64'(m_ntag));
    chk("new_index",   64'(newIndex_o),    64'(m_nidx));

    clear_out();
    if (rst) begin
      q.delete();
      starve = 0;
    end else begin
      if (sz == 0 || g == 2)          starve = 0;
      else if (g == 1 && starve < SL) starve = starve + 1;
      if (g == 1) begin
        m_fe = 1; m_tag = ftag; m_idx = fidx; m_off = foff;
      end else if (g == 2) begin
        e = q.pop_front();
        m_ue = 1; m_ntag = e.tag; m_nidx = e.idx;
      end
      if (uv && rdy) q.push_back('{tag: utag, idx: uidx});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fv = 0; ftag = '0; fidx = '0; foff = '0;
    uv = 0; utag = '0; uidx = '0;
  endtask

  int nf;

  initial begin
    rst = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    q.delete(); starve = 0; clear_out();

    // Reset state
    chk("rst_fetch_en",  64'(fetchEnable_o),  64'd0);
    chk("rst_update_en", 64'(updateEnable_o), 64'd0);
    chk("rst_count",     64'(updCount_o),     64'd0);
    chk("rst_upd_ready", 64'(updReady_o),     64'd0);
    step();
    rst = 0;
    step();

    // Fetch only
    fv = 1; ftag = TS'(64'hABC); fidx = 8'h12; foff = 5'h04;
    #1 chk("r026_fetch_ready", 64'(fetchReady_o), 64'd1);
    step();
    idle_inputs();
    #1;
    chk("r026_fetch_en",  64'(fetchEnable_o), 64'd1);
    chk("r026_index",     64'(index_o),       64'h12);
    chk("r026_offset",    64'(offset_o),      64'h04);
    chk("r026_new_index", 64'(newIndex_o),    64'd0);
    step();

    // Update while idle
    uv = 1; utag = TS'(1); uidx = 8'h40;
    step();
    idle_inputs();
    #1 chk("r027_count_after_push", 64'(updCount_o), 64'd1);
    step();
    chk("r027_update_en", 64'(updateEnable_o), 64'd1);
    chk("r027_new_index", 64'(newIndex_o),     64'h40);
    chk("r027_index",     64'(index_o),        64'd0);
    chk("r027_count",     64'(updCount_o),     64'd0);
    step();

    // Starvation limit
    uv = 1; utag = TS'(64'h55); uidx = 8'h55;
    step();
    uv = 0; fv = 1; fidx = 8'h01;
    nf = 0;
    for (int i = 0; i < 10; i++) begin
      ftag = TS'({$urandom, $urandom});
      foff = OS'($urandom);
      #1;
      if (!fetchReady_o) break;
      nf++;
      step();
    end
    chk("r028_fetch_grants", 64'(nf), 64'd4);
    step();
    chk("r028_update_en",    64'(updateEnable_o), 64'd1);
    chk("r028_fetch_resume", 64'(fetchReady_o),   64'd1);
    step();
    idle_inputs();
    step();

    // Index hazard
    uv = 1; utag = TS'(64'h77); uidx = 8'h33;
    step();
    uv = 0; fv = 1; fidx = 8'h33; ftag = TS'(64'h99);
    #1;
    chk("r029_hazard",      64'(hazardStall_o), 64'd1);
    chk("r029_fetch_ready", 64'(fetchReady_o),  64'd0);
    step();
    chk("r029_fetch_after", 64'(fetchReady_o),  64'd1);
    chk("r029_hazard_clr",  64'(hazardStall_o), 64'd0);
    step();
    idle_inputs();
    step();

    // Full FIFO with fetches held high
    fv = 1; fidx = 8'h02;
    uv = 1; uidx = 8'h10; utag = TS'(64'h10);
    step();
    uidx = 8'h11; utag = TS'(64'h11);
    step();
    uidx = 8'h12; utag = TS'(64'h12);
    #1;
    chk("r030_count_full", 64'(updCount_o), 64'd2);
    chk("r030_not_ready",  64'(updReady_o), 64'd0);
    for (int i = 0; i < 10 && !updReady_o; i++) step();
    chk("r030_ready_again", 64'(updReady_o), 64'd1);
    step();
    idle_inputs();
    repeat (5) step();
    chk("r030_drained", 64'(updCount_o), 64'd0);

    // Reset with two queued updates
    fv = 1; fidx = 8'h03;
    uv = 1; uidx = 8'h20; utag = TS'(64'h20);
    step();
    uidx = 8'h21; utag = TS'(64'h21);
    step();
    idle_inputs();
    #1 chk("r031_count_full", 64'(updCount_o), 64'd2);
    rst = 1;
    #1 chk("r031_ready_in_rst", 64'(updReady_o), 64'd0);
    step();
    rst = 0;
    chk("r031_count",     64'(updCount_o),     64'd0);
    chk("r031_no_update", 64'(updateEnable_o), 64'd0);
    step();
    chk("r031_no_update2", 64'(updateEnable_o), 64'd0);
    step();

    // Randomized traffic on a small index set to provoke hazards
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 63) == 0);
      fv   = ($urandom_range(0, 3) != 0);
      ftag = TS'({$urandom, $urandom});
      fidx = IS'($urandom_range(0, 3));
      foff = OS'($urandom);
      uv   = ($urandom_range(0, 2) == 0);
      utag = TS'({$urandom, $urandom});
      uidx = IS'($urandom_range(0, 3));
      step();
    end
    rst = 0;
    idle_inputs();
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tag_port_arbiter.md
TAG_PORT_ARBITER -- requirements
Module: tag_port_arbiter

Interface
REQ-001 SHALL have parameters: OFFSET_SIZE, default 5, byte-offset width; INDEX_SIZE, default 8, line-index width; TAG_SIZE, default 64-(OFFSET_SIZE+INDEX_SIZE), tag width; STARVE_LIMIT, default 4, maximum consecutive fetch grants while an update waits.
REQ-002 SHALL have ports: clock_i  in  1  sole clock, rising edge; reset_i  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: fetchValid_i  in  1  lookup request; fetchTag_i  in  TAG_SIZE; fetchIndex_i  in  INDEX_SIZE; fetchOffset_i  in  OFFSET_SIZE; fetchReady_o  out  1  lookup accepted this cycle.
REQ-004 SHALL have ports: updValid_i  in  1  tag-write request from refill; updTag_i  in  TAG_SIZE; updIndex_i  in  INDEX_SIZE; updReady_o  out  1  update FIFO not full.
REQ-005 SHALL have ports to the tag-query stage: fetchEnable_o  out  1; tag_o  out  TAG_SIZE; index_o  out  INDEX_SIZE; offset_o  out  OFFSET_SIZE; updateEnable_o  out  1; newTag_o  out  TAG_SIZE; newIndex_o  out  INDEX_SIZE.
REQ-006 SHALL have ports: updCount_o  out  2  update FIFO occupancy (0..2); hazardStall_o  out  1  fetch held by index hazard.

Function
REQ-007 SHALL buffer updates in a 2-entry FIFO; push when updValid_i && updReady_o; updReady_o = (count < 2), derived from registered count only.
REQ-008 SHALL, each cycle, grant at most one of: FETCH, UPDATE, NONE.
REQ-009 SHALL grant UPDATE when FIFO non-empty and (fetchValid_i==0, or starveCnt==STARVE_LIMIT, or hazard); else FETCH when fetchValid_i; else NONE.
REQ-010 Hazard SHALL be asserted when fetchValid_i and fetchIndex_i equals the index of any valid FIFO entry; hazardStall_o = hazard.
REQ-011 fetchReady_o SHALL be combinational and equal (grant==FETCH).
REQ-012 starveCnt SHALL increment on FETCH grant while FIFO non-empty, saturate at STARVE_LIMIT, and clear on UPDATE grant or when FIFO is empty.
REQ-013 Outputs to the tag-query stage SHALL be registered: one cycle after grant, exactly one enable high for one cycle.
REQ-014 On FETCH grant: next cycle fetchEnable_o=1, tag_o/index_o/offset_o = accepted request, updateEnable_o=0, newTag_o=0, newIndex_o=0.
REQ-015 On UPDATE grant: pop FIFO head; next cycle updateEnable_o=1, newTag_o/newIndex_o = head entry, fetchEnable_o=0, tag_o=0, index_o=0, offset_o=0.
REQ-016 On NONE: next cycle both enables 0 and all address/tag outputs 0.
REQ-017 fetchEnable_o and updateEnable_o SHALL never be high in the same cycle; the unused index output SHALL always be zero.
REQ-018 Simultaneous push and pop SHALL be legal at any count; with count==2, push is blocked by updReady_o=0 even if a pop occurs that cycle.
REQ-019 A pushed entry SHALL not be eligible for grant in its push cycle; it is eligible from the next cycle.
REQ-020 FIFO order SHALL be strict FIFO; pointers wrap modulo 2.

Reset
REQ-021 While reset_i high at a rising edge: FIFO count, pointers and starveCnt cleared; all outputs registered to 0; in-flight entries discarded.
REQ-022 fetchReady_o SHALL be 0 and updReady_o SHALL be 0 during any cycle with reset_i high; grant forced to NONE.
REQ-023 Reset mid-operation SHALL discard queued updates with no enable pulse on the following cycle.

Structure
REQ-024 Shared package SHALL hold the size defaults and the grant encoding (NONE=0, FETCH=1, UPDATE=2).
REQ-025 The 2-entry update FIFO SHALL be a sub-module named tag_update_fifo exposing entry indices for hazard comparison.

Verification
REQ-026 Fetch only: fetchValid_i=1, index 0x12, offset 0x04 -> fetchReady_o=1 same cycle; next cycle fetchEnable_o=1, index_o=0x12, offset_o=0x04, newIndex_o=0.
REQ-027 Update while idle: push tag 0x1, index 0x40 -> next cycle granted; following cycle updateEnable_o=1, newIndex_o=0x40, index_o=0, updCount_o back to 0.
REQ-028 Starvation: one queued update plus continuous fetches to index 0x01 -> exactly 4 fetch grants, then UPDATE grant with fetchReady_o=0 for one cycle.
REQ-029 Hazard: queued update index 0x33, fetch to 0x33 -> hazardStall_o=1, fetchReady_o=0 until update granted; fetch granted the next cycle.
REQ-030 Full FIFO: push 3 updates on consecutive cycles with fetchValid_i held high -> updReady_o=0 at count 2; third push held until a pop; order preserved.
REQ-031 Reset with count 2: assert reset_i one cycle -> updCount_o=0, no updateEnable_o pulse afterwards.
